cache_mem_rsp: RTL and testbench



---
 rtl/cache_mem_rsp.sv | 152 +++++++++++++++
 tb/tb_cache_mem_rsp.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_rsp.sv
// Downstream memory responder: accepts one bus request at a time, services it
// against a small block memory after a fixed latency and returns the result.
module cache_mem_rsp #(
   parameter int unsigned SADDR_WIDTH = 26,
   parameter int unsigned BLK_WIDTH   = 512,
   parameter int unsigned MEM_DEPTH   = 16,
   parameter int unsigned LATENCY     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sdreq_valid,
   input  logic [2:0]             sdreq_op,
   input  logic [SADDR_WIDTH-1:0] sdreq_addr,
   input  logic [BLK_WIDTH-1:0]   sdreq_data,
   output logic                   sdreq_ready,
   output logic                   sursp_valid,
   output logic [2:0]             sursp_rsp,
   output logic [BLK_WIDTH-1:0]   sursp_data,
   input  logic                   sursp_ready
);

   localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [2:0] OP_GETS    = 3'd0;
   localparam logic [2:0] OP_GETM    = 3'd1;
   localparam logic [2:0] OP_PUTM    = 3'd2;
   localparam logic [2:0] OP_UPGR    = 3'd3;
   localparam logic [2:0] RSP_DATA   = 3'd1;
   localparam logic [2:0] RSP_DATA_X = 3'd2;
   localparam logic [2:0] RSP_ACK    = 3'd3;
   localparam logic [2:0] RSP_ERR    = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RSP  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2:0]           code_q, code_d;
   logic [BLK_WIDTH-1:0] snap_q, snap_d;
   logic                 ready_d, valid_d;
   logic [2:0]           rsp_d;
   logic [BLK_WIDTH-1:0] data_d;
   logic [BLK_WIDTH-1:0] mem_q [MEM_DEPTH];
   logic [IDX_W-1:0]     idx;
   logic                 req_hs;
   logic                 is_read;
   logic                 unused_addr;

   // Upper address bits alias onto the same entries and are deliberately dropped.
   assign idx         = sdreq_addr[IDX_W-1:0];
   assign unused_addr = ^sdreq_addr[SADDR_WIDTH-1:IDX_W];
   assign req_hs      = sdreq_valid && sdreq_ready;
   assign is_read     = (sdreq_op == OP_GETS) || (sdreq_op == OP_GETM);

   function automatic logic [2:0] op_to_rsp(input logic [2:0] op);
      case (op)
         OP_GETS: op_to_rsp = RSP_DATA;
         OP_GETM: op_to_rsp = RSP_DATA_X;
         OP_PUTM,
         OP_UPGR: op_to_rsp = RSP_ACK;
         default: op_to_rsp = RSP_ERR;
      endcase
   endfunction

   // State, latched response and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         code_q      <= '0;
         snap_q      <= '0;
         sdreq_ready <= 1'b0;
         sursp_valid <= 1'b0;
         sursp_rsp   <= '0;
         sursp_data  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         code_q      <= code_d;
         snap_q      <= snap_d;
         sdreq_ready <= ready_d;
         sursp_valid <= valid_d;
         sursp_rsp   <= rsp_d;
         sursp_data  <= data_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      snap_d  = snap_q;
      ready_d = sdreq_ready;
      valid_d = sursp_valid;
      rsp_d   = sursp_rsp;
      data_d  = sursp_data;
      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (req_hs) begin
               ready_d = 1'b0;
               code_d  = op_to_rsp(sdreq_op);
               snap_d  = is_read ? mem_q[idx] : '0;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = (LATENCY == 1) ? RSP : WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RSP;
               valid_d = 1'b1;
               rsp_d   = code_q;
               data_d  = snap_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RSP: begin
            // Entered straight from IDLE when the latency is one: raise valid a cycle later.
            if (!sursp_valid) begin
               valid_d = 1'b1;
               rsp_d   = code_q;
               data_d  = snap_q;
            end else if (sursp_ready) begin
               valid_d = 1'b0;
               rsp_d   = '0;
               data_d  = '0;
               ready_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Block memory; the read snapshot above sees the pre-write contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (req_hs && (sdreq_op == OP_PUTM)) begin
         mem_q[idx] <= sdreq_data;
      end
   end

endmodule

// File: tb/tb_cache_mem_rsp.sv
// Bench for cache_mem_rsp: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level timeline model.
module tb_cache_mem_rsp;

   localparam int unsigned AW  = 26;
   localparam int unsigned BW  = 512;
   localparam int unsigned DEP = 16;
   localparam int unsigned LAT = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          sdreq_valid = 1'b0;
   logic [2:0]    sdreq_op = '0;
   logic [AW-1:0] sdreq_addr = '0;
   logic [BW-1:0] sdreq_data = '0;
   logic          sdreq_ready;
   logic          sursp_valid;
   logic [2:0]    sursp_rsp;
   logic [BW-1:0] sursp_data;
   logic          sursp_ready;
   logic          rand_mode = 1'b0;
   logic          dir_ready = 1'b1;
   logic          rnd_ready = 1'b1;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   assign sursp_ready = rand_mode ? rnd_ready : dir_ready;

   cache_mem_rsp #(
      .SADDR_WIDTH(AW), .BLK_WIDTH(BW), .MEM_DEPTH(DEP), .LATENCY(LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .sdreq_valid(sdreq_valid), .sdreq_op(sdreq_op), .sdreq_addr(sdreq_addr),
      .sdreq_data(sdreq_data), .sdreq_ready(sdreq_ready),
      .sursp_valid(sursp_valid), .sursp_rsp(sursp_rsp), .sursp_data(sursp_data),
      .sursp_ready(sursp_ready)
   );

   always #5 clk = ~clk;

   // Edge counter: value read at an edge is that edge's number.
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) rnd_ready <= 1'($urandom_range(0, 1));

   task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] rand_blk();
      logic [BW-1:0] v;
      for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [2:0] rsp_of(input logic [2:0] op);
      case (op)
         3'd0: return 3'd1;
         3'd1: return 3'd2;
         3'd2, 3'd3: return 3'd3;
         default: return 3'd7;
      endcase
   endfunction

   // ---------------- reference model ----------------
   logic [BW-1:0] m_mem [DEP];
   logic          m_ready = 1'b0, m_valid = 1'b0, m_busy = 1'b0;
   logic [2:0]    m_rsp = '0, p_rsp = '0;
   logic [BW-1:0] m_data = '0, p_data = '0;
   int            p_at = 0;
   int unsigned   m_idx;

   assign m_idx = int'(sdreq_addr) % DEP;

   // Timeline model: accept at edge A, response from edge A+LAT until it is taken.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ready <= 1'b0; m_valid <= 1'b0; m_busy <= 1'b0;
         m_rsp <= '0; m_data <= '0;
         for (int i = 0; i < DEP; i++) m_mem[i] <= '0;
      end else begin
         if (m_valid && sursp_ready) begin
            m_valid <= 1'b0; m_rsp <= '0; m_data <= '0;
            m_ready <= 1'b1; m_busy <= 1'b0;
         end else if (m_ready && sdreq_valid) begin
            m_ready <= 1'b0;
            m_busy  <= 1'b1;
            p_at    <= cyc + LAT;
            p_rsp   <= rsp_of(sdreq_op);
            p_data  <= (sdreq_op <= 3'd1) ? m_mem[m_idx] : '0;
            if (sdreq_op == 3'd2) m_mem[m_idx] <= sdreq_data;
         end else if (!m_busy) begin
            m_ready <= 1'b1;
         end
         if (m_busy && !m_valid && cyc == p_at) begin
            m_valid <= 1'b1; m_rsp <= p_rsp; m_data <= p_data;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      check("sdreq_ready", BW'(sdreq_ready), BW'(m_ready));
      check("sursp_valid", BW'(sursp_valid), BW'(m_valid));
      check("sursp_rsp",   BW'(sursp_rsp),   BW'(m_rsp));
      check("sursp_data",  sursp_data,       m_data);
   end

   // ---------------- stimulus helpers (called at negedge) ----------------
   task automatic issue(input logic [2:0] op, input logic [AW-1:0] addr,
                        input logic [BW-1:0] data, output int acc_edge);
      sdreq_valid = 1'b1; sdreq_op = op; sdreq_addr = addr; sdreq_data = data;
      acc_edge = -1;
      for (int i = 0; i < 60; i++) begin
         if (sdreq_ready) begin
            acc_edge = cyc;
            @(negedge clk);
            sdreq_valid = 1'b0;
            sdreq_op    = 3'($urandom);
            sdreq_addr  = AW'($urandom);
            sdreq_data  = rand_blk();
            return;
         end
         @(negedge clk);
      end
      sdreq_valid = 1'b0;
      check("accept_timeout", 1, 0);
   endtask

   task automatic wait_rsp(output int v_edge, output logic [2:0] rsp, output logic [BW-1:0] data);
      v_edge = -1; rsp = '0; data = '0;
      for (int i = 0; i < 60; i++) begin
         if (sursp_valid) begin
            v_edge = cyc - 1; rsp = sursp_rsp; data = sursp_data;
            return;
         end
         @(negedge clk);
      end
      check("response_timeout", 1, 0);
   endtask

   // ---------------- directed + random scenarios ----------------
   initial begin
      int a, v, gap;
      logic [2:0]    r;
      logic [BW-1:0] d, pat, hold_d;
      logic [2:0]    hold_r;

      for (int i = 0; i < BW / 8; i++) pat[i*8 +: 8] = 8'hA5;

      // Reset / idle
      #1 rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("ready_in_reset", BW'(sdreq_ready), 0);
         check("valid_in_reset", BW'(sursp_valid), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", BW'(sdreq_ready), 1);

      // Cold read
      issue(3'd0, AW'(5), rand_blk(), a);
      wait_rsp(v, r, d);
      check("cold_latency", BW'(v - a), BW'(LAT));
      check("cold_rsp", BW'(r), 1);
      check("cold_data", d, '0);
      @(negedge clk);

      // Write then aliased read
      issue(3'd2, AW'(3), pat, a);
      wait_rsp(v, r, d);
      check("putm_rsp", BW'(r), 3);
      check("putm_data", d, '0);
      @(negedge clk);
      issue(3'd1, AW'('h13), rand_blk(), a);
      wait_rsp(v, r, d);
      check("getm_alias_rsp", BW'(r), 2);
      check("getm_alias_data", d, pat);
      @(negedge clk);

      // Backpressure with a competing request
      dir_ready = 1'b0;
      issue(3'd0, AW'(3), rand_blk(), a);
      wait_rsp(v, hold_r, hold_d);
      sdreq_valid = 1'b1; sdreq_op = 3'd0; sdreq_addr = AW'(5);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", BW'(sursp_valid), 1);
         check("bp_rsp", BW'(sursp_rsp), 1);
         check("bp_data", sursp_data, pat);
         check("bp_no_accept", BW'(sdreq_ready), 0);
         @(negedge clk);
      end
      dir_ready = 1'b1; sdreq_valid = 1'b0;
      @(negedge clk);
      check("bp_done_valid", BW'(sursp_valid), 0);
      check("bp_done_ready", BW'(sdreq_ready), 1);

      // Illegal op leaves memory alone
      issue(3'd6, AW'(3), rand_blk(), a);
      wait_rsp(v, r, d);
      check("err_rsp", BW'(r), 7);
      check("err_data", d, '0);
      @(negedge clk);
      issue(3'd0, AW'('h23), rand_blk(), a);
      wait_rsp(v, r, d);
      check("after_err_data", d, pat);
      @(negedge clk);

      // Reset mid-WAIT
      issue(3'd2, AW'(7), rand_blk(), a);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_clear_valid", BW'(sursp_valid), 0);
      check("async_clear_ready", BW'(sdreq_ready), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (LAT + 2) begin
         @(negedge clk);
         check("dropped_no_valid", BW'(sursp_valid), 0);
      end
      issue(3'd0, AW'(7), rand_blk(), a);
      wait_rsp(v, r, d);
      check("post_reset_rsp", BW'(r), 1);
      check("post_reset_data", d, '0);
      @(negedge clk);
      issue(3'd0, AW'(3), rand_blk(), a);
      wait_rsp(v, r, d);
      check("post_reset_cleared", d, '0);
      @(negedge clk);

      // Randomized traffic with random response backpressure
      rand_mode = 1'b1;
      for (int n = 0; n < 300; n++) begin
         logic [AW-1:0] ad;
         ad = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 5));
         issue(3'($urandom_range(0, 7)), ad, rand_blk(), a);
         gap = $urandom_range(0, 2);
         repeat (gap) @(negedge clk);
      end
      rand_mode = 1'b0;
      dir_ready = 1'b1;
      repeat (LAT + 4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
